// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 8x8 unsigned multiplier that borrows the CPU ALU for each partial-product add.
// Drives ALU opcode/operands and the active-low bus strobes, reading the sum and carry back over bus_in.
module alu_mul_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter logic [4:0]  OP_ADD    = 5'b00111,
  parameter logic [4:0]  OP_IDLE   = 5'b00000,
  parameter int unsigned CARRY_BIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [4:0]           opcode,
  output logic [WIDTH-1:0]     reg_a,
  output logic [WIDTH-1:0]     reg_b,
  output logic                 alu_out,
  output logic                 reg_f_out,
  output logic                 reg_f_load,
  input  logic [WIDTH-1:0]     bus_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST,
    S_ADD,
    S_FLAGS,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] acc_a;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] m;
  logic             carry;
  logic [3:0]       cnt;

  // Right shift of {carry, p_hi, m}; the low 2*WIDTH bits are the new {p_hi, m}.
  logic [2*WIDTH-1:0] shifted;
  assign shifted = {carry, p_hi, m[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // product is written on the SHIFT->DONE edge so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a   <= '0;
      p_hi    <= '0;
      m       <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc_a <= a_in;
            m     <= b_in;
            p_hi  <= '0;
            carry <= 1'b0;
            cnt   <= 4'd8;
          end
        end
        S_TEST: begin
          if (!m[0]) carry <= 1'b0;
        end
        S_ADD: begin
          p_hi <= bus_in;
        end
        S_FLAGS: begin
          carry <= bus_in[CARRY_BIT];
        end
        S_SHIFT: begin
          {p_hi, m} <= shifted;
          cnt       <= cnt - 4'd1;
          if (cnt == 4'd1) product <= shifted;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    opcode     = OP_IDLE;
    reg_a      = '0;
    reg_b      = '0;
    alu_out    = 1'b1;
    reg_f_out  = 1'b1;
    reg_f_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_TEST;
      end
      S_TEST: begin
        state_nxt = m[0] ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        opcode     = OP_ADD;
        reg_a      = p_hi;
        reg_b      = acc_a;
        alu_out    = 1'b0;
        reg_f_load = 1'b1;
        state_nxt  = S_FLAGS;
      end
      S_FLAGS: begin
        opcode    = OP_ADD;
        reg_f_out = 1'b0;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        state_nxt = (cnt == 4'd1) ? S_DONE : S_TEST;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU on the shared bus.
// Expected products and done cycles go into a queue at start and are popped when done pulses.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a_in, b_in, bus_in;
  logic        busy, done;
  logic [15:0] product;
  logic [4:0]  opcode;
  logic [7:0]  reg_a, reg_b;
  logic        alu_out, reg_f_out, reg_f_load;

  alu_mul_sequencer #(
    .WIDTH(8),
    .OP_ADD(5'b00111),
    .OP_IDLE(5'b00000),
    .CARRY_BIT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product), .opcode(opcode),
    .reg_a(reg_a), .reg_b(reg_b), .alu_out(alu_out), .reg_f_out(reg_f_out),
    .reg_f_load(reg_f_load), .bus_in(bus_in)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: flags byte is {zero-padding, carry at bit 3, zero flag at bit 0}.
  logic [8:0] sum;
  logic [7:0] result;
  logic [4:0] alu_flags;
  assign sum    = {1'b0, reg_a} + {1'b0, reg_b};
  assign result = (opcode == 5'b00111) ? sum[7:0] : 8'h00;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_flags <= 5'd0;
    else if (reg_f_load)
      alu_flags <= {1'b0, (opcode == 5'b00111) ? sum[8] : 1'b0, 2'b00, (result == 8'h00)};
  end
  assign bus_in = !alu_out ? result : (!reg_f_out ? {3'b000, alu_flags} : 8'hA5);

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] prod;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int   add_cnt, fl_cnt, strobe_bad, idle_bad, active_cnt, done_cnt;
  logic carry2;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!alu_out) add_cnt++;
      if (!reg_f_out) begin
        fl_cnt++;
        if (fl_cnt == 2) carry2 = bus_in[3];
      end
      if (!alu_out && !reg_f_out) strobe_bad++;
      if (reg_f_load && alu_out) strobe_bad++;
      if (!alu_out || !reg_f_out || reg_f_load) active_cnt++;
      if (alu_out && reg_f_out && (opcode != 5'd0 || reg_a != 8'd0 || reg_b != 8'd0 || reg_f_load))
        idle_bad++;
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy"},       busy,       0);
    chk({pfx, "_done"},       done,       0);
    chk({pfx, "_product"},    product,    0);
    chk({pfx, "_opcode"},     opcode,     0);
    chk({pfx, "_reg_a"},      reg_a,      0);
    chk({pfx, "_reg_b"},      reg_b,      0);
    chk({pfx, "_alu_out"},    alu_out,    1);
    chk({pfx, "_reg_f_out"},  reg_f_out,  1);
    chk({pfx, "_reg_f_load"}, reg_f_load, 0);
  endtask

  // Runs one multiply; repulse>0 re-raises start in that cycle, rst_at>0 resets in that cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_prod,
                        input int repulse, input int rst_at);
    exp_t e;
    int   dcyc;
    logic [15:0] dprod;
    @(negedge clk);
    add_cnt = 0; fl_cnt = 0; strobe_bad = 0; idle_bad = 0; active_cnt = 0; done_cnt = 0;
    carry2 = 1'b0;
    a_in = a; b_in = b; start = 1'b1;
    if (rst_at == 0) begin
      e.prod = exp_prod;
      e.cyc  = 17 + 2 * $countones(b);
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
    dcyc  = -1;
    dprod = 16'hxxxx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) chk("busy_rise", busy, 1);
      if (repulse > 0 && n == repulse) begin
        start = 1'b1; a_in = 8'd2; b_in = 8'd2;
      end
      if (repulse > 0 && n == repulse + 1) start = 1'b0;
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1 chk_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        dcyc  = n;
        dprod = product;
        break;
      end
    end
    e = sb.pop_front();
    chk("product", dprod, e.prod);
    chk("done_cycle", dcyc, e.cyc);
    @(negedge clk);
    chk("busy_fall", busy, 0);
    repeat (3) @(negedge clk);
    chk("product_held", product, e.prod);
    chk("done_pulses", done_cnt, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a_in = 8'd0; b_in = 8'd0;
    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd13, 8'd11, 16'h008F, 0, 0);
    chk("add_cycles_13x11", add_cnt, 3);
    chk("strobes_13x11", strobe_bad, 0);
    chk("idle_drive_13x11", idle_bad, 0);

    run_op(8'hFF, 8'hFF, 16'hFE01, 0, 0);
    chk("carry_iter1", carry2, 1);
    chk("add_cycles_ffxff", add_cnt, 8);

    run_op(8'h80, 8'h00, 16'h0000, 0, 0);
    chk("strobes_inactive", active_cnt, 0);

    run_op(8'hFF, 8'h03, 16'h02FD, 0, 0);
    chk("strobes_ffx03", strobe_bad, 0);
    chk("idle_drive_ffx03", idle_bad, 0);

    run_op(8'd5, 8'd7, 16'h0023, 6, 0);

    run_op(8'hFF, 8'hFF, 16'h0000, 0, 10);
    #1 chk_reset_outputs("post_reset");

    run_op(8'd3, 8'd4, 16'h000C, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
